// File: rtl/demux_2powern_hs_pkg.sv
// rtl/demux_2powern_hs_pkg.sv - shared constants and buffer state type for the MDR demux
package pkg_system_mdr;

    localparam int MDR_DEMUX_SEL  = 2;
    localparam int MDR_DDW        = 16;
    localparam int MDR_DROP_CNT_W = 8;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } demux_buf_st_e;

endpackage

// File: rtl/demux_2powern_hs_chan_buf.sv
// rtl/demux_2powern_hs_chan_buf.sv - one-entry valid/ready output buffer for one demux channel
module demux_chan_buf
    import pkg_system_mdr::*;
#(
    parameter int DDW = MDR_DDW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic [DDW-1:0] i_data,
    input  logic           i_ready,
    output logic           o_valid,
    output logic [DDW-1:0] o_data
);

    demux_buf_st_e  state_q, state_d;
    logic [DDW-1:0] data_q, data_d;
    logic           drain;

    // The top only raises i_load when this buffer is empty or draining this cycle.
    always_comb begin
        drain   = (state_q == BUF_FULL) && i_ready;
        state_d = state_q;
        data_d  = data_q;
        if (i_load) begin
            state_d = BUF_FULL;
            data_d  = i_data;
        end else if (drain) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = (state_q == BUF_FULL);
    assign o_data  = data_q;

endmodule

// File: rtl/demux_2powern_hs.sv
// rtl/demux_2powern_hs.sv - registered handshaked 1-to-NUM_CH demux with drop counter
// Optional broadcast input i_bcast is enabled by defining DEMUX_BROADCAST_EN.
module demux_2powern_hs
    import pkg_system_mdr::*;
#(
    parameter int MUX_SEL = MDR_DEMUX_SEL,
    parameter int DDW     = MDR_DDW,
    parameter int NUM_CH  = 2**MUX_SEL,
    parameter int CNT_W   = MDR_DROP_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic [MUX_SEL-1:0]             i_sltr,
`ifdef DEMUX_BROADCAST_EN
    input  logic                           i_bcast,
`endif
    input  logic [DDW-1:0]                 i_bus,
    output logic                           o_ready,
    output logic [NUM_CH-1:0]              o_valid,
    output logic [NUM_CH-1:0][DDW-1:0]     o_buses,
    input  logic [NUM_CH-1:0]              i_ready,
    output logic                           o_err,
    output logic [CNT_W-1:0]               o_drop_cnt
);

    localparam int SEL_SPAN = 1 << MUX_SEL;

    logic [SEL_SPAN-1:0] chan_free;
    logic [NUM_CH-1:0]   load;
    logic                sel_legal;
    logic                bcast_req;
    logic                all_free;
    logic                accept;
    logic                drop;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

`ifdef DEMUX_BROADCAST_EN
    assign bcast_req = i_bcast;
`else
    assign bcast_req = 1'b0;
`endif

    // Selector slots beyond NUM_CH stay 0 so free lookup never indexes out of range.
    always_comb begin
        chan_free = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            chan_free[k] = !o_valid[k] || i_ready[k];
        end
        all_free  = &chan_free[NUM_CH-1:0];
        sel_legal = int'(i_sltr) < NUM_CH;

        if (bcast_req) begin
            o_ready = all_free;
        end else if (sel_legal) begin
            o_ready = chan_free[i_sltr];
        end else begin
            o_ready = 1'b1;
        end

        accept = i_valid && o_ready;
        load   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = accept && (bcast_req || (sel_legal && (i_sltr == MUX_SEL'(k))));
        end

        drop  = accept && !bcast_req && !sel_legal;
        err_d = drop;
        cnt_d = cnt_q;
        if (drop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_err      = err_q;
    assign o_drop_cnt = cnt_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        demux_chan_buf #(
            .DDW (DDW)
        ) u_buf (
            .clk     (clk),
            .rst     (rst),
            .i_load  (load[k]),
            .i_data  (i_bus),
            .i_ready (i_ready[k]),
            .o_valid (o_valid[k]),
            .o_data  (o_buses[k])
        );
    end

endmodule

// File: tb/tb_demux_2powern_hs.sv
// tb/tb_demux_2powern_hs.sv - scoreboard bench for demux_2powern_hs (4-channel and 3-channel builds)
module tb_demux_2powern_hs;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic [1:0]       i_sltr;
    logic [15:0]      i_bus;
    logic             i_bcast;
    logic             o_ready;
    logic [3:0]       o_valid;
    logic [3:0][15:0] o_buses;
    logic [3:0]       i_ready;
    logic             o_err;
    logic [7:0]       o_drop_cnt;

    logic             i_valid3;
    logic [1:0]       i_sltr3;
    logic [15:0]      i_bus3;
    logic             o_ready3;
    logic [2:0]       o_valid3;
    logic [2:0][15:0] o_buses3;
    logic [2:0]       i_ready3;
    logic             o_err3;
    logic [7:0]       o_drop_cnt3;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int err_pulses3 = 0;
    int valid3_seen = 0;
    logic [15:0] exp_q[4][$];

    demux_2powern_hs #(.MUX_SEL(2), .DDW(16), .NUM_CH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sltr(i_sltr),
`ifdef DEMUX_BROADCAST_EN
        .i_bcast(i_bcast),
`endif
        .i_bus(i_bus), .o_ready(o_ready), .o_valid(o_valid), .o_buses(o_buses),
        .i_ready(i_ready), .o_err(o_err), .o_drop_cnt(o_drop_cnt)
    );

    demux_2powern_hs #(.MUX_SEL(2), .DDW(16), .NUM_CH(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .i_valid(i_valid3), .i_sltr(i_sltr3),
`ifdef DEMUX_BROADCAST_EN
        .i_bcast(1'b0),
`endif
        .i_bus(i_bus3), .o_ready(o_ready3), .o_valid(o_valid3), .o_buses(o_buses3),
        .i_ready(i_ready3), .o_err(o_err3), .o_drop_cnt(o_drop_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected word for that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (o_valid[k] && i_ready[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_xfer ch%0d actual=%0h required=none", k, o_buses[k]);
                    end else begin
                        logic [15:0] e;
                        e = exp_q[k].pop_front();
                        if (o_buses[k] !== e) begin
                            errors++;
                            $display("FAIL xfer_data ch%0d actual=%0h required=%0h", k, o_buses[k], e);
                        end
                    end
                end
            end
            if (o_err)       err_pulses++;
            if (o_err3)      err_pulses3++;
            if (|o_valid3)   valid3_seen++;
        end
    end

    initial begin
        int bad_ready;
        rst = 1'b1; i_valid = 0; i_sltr = 0; i_bus = 0; i_bcast = 0; i_ready = 4'b1111;
        i_valid3 = 0; i_sltr3 = 0; i_bus3 = 0; i_ready3 = 3'b111;
        tick(); tick();
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_buses", o_buses, 0);
        chk("reset_o_err", o_err, 0);
        chk("reset_drop_cnt", o_drop_cnt, 0);
        rst = 1'b0;
        tick();

        // unicast to ch2
        i_valid = 1; i_sltr = 2; i_bus = 16'hA5A5; exp_q[2].push_back(16'hA5A5);
        #1 chk("uni_o_ready", o_ready, 1);
        tick();
        i_valid = 0;
        chk("uni_o_valid", o_valid, 4'b0100);
        chk("uni_bus2", o_buses[2], 16'hA5A5);
        tick();
        chk("uni_o_valid_drained", o_valid, 0);

        // back-pressure on ch1
        i_ready = 4'b1101;
        i_valid = 1; i_sltr = 1; i_bus = 16'h0001; exp_q[1].push_back(16'h0001);
        tick();
        i_bus = 16'h0002; exp_q[1].push_back(16'h0002);
        #1 chk("bp_o_ready_low", o_ready, 0);
        tick();
        chk("bp_o_ready_still_low", o_ready, 0);
        chk("bp_bus1_stable", o_buses[1], 16'h0001);
        chk("bp_o_valid", o_valid, 4'b0010);
        i_ready = 4'b1111;
        #1 chk("bp_o_ready_release", o_ready, 1);
        tick();
        i_valid = 0;
        chk("bp_bus1_new", o_buses[1], 16'h0002);
        tick();

        // streaming 0..7 to ch0
        for (int i = 0; i < 8; i++) begin
            i_valid = 1; i_sltr = 0; i_bus = 16'(i); exp_q[0].push_back(16'(i));
            #1 chk("stream_o_ready", o_ready, 1);
            tick();
            chk("stream_bus0", o_buses[0], 16'(i));
        end
        i_valid = 0;
        tick(); tick();

        // async reset while ch0 and ch3 are full
        i_ready = 4'b0000;
        i_valid = 1; i_sltr = 0; i_bus = 16'h1111; exp_q[0].push_back(16'h1111);
        tick();
        i_sltr = 3; i_bus = 16'h3333; exp_q[3].push_back(16'h3333);
        tick();
        i_valid = 0;
        chk("ar_o_valid_before", o_valid, 4'b1001);
        #2 rst = 1'b1;
        #1;
        chk("ar_o_valid", o_valid, 0);
        chk("ar_o_buses", o_buses, 0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        tick();
        rst = 1'b0; i_ready = 4'b1111;
        tick();

        // 3-channel build: highest legal selector, then drop path
        i_valid3 = 1; i_sltr3 = 2; i_bus3 = 16'h0C0C;
        tick();
        i_valid3 = 0;
        chk("n3_legal_valid", o_valid3, 3'b100);
        chk("n3_legal_bus", o_buses3[2], 16'h0C0C);
        chk("n3_legal_no_err", o_err3, 0);
        tick();
        valid3_seen = 0;
        bad_ready = 0;
        i_valid3 = 1; i_sltr3 = 3; i_bus3 = 16'hDEAD;
        for (int i = 0; i < 300; i++) begin
            #1 if (o_ready3 !== 1'b1) bad_ready++;
            tick();
            if (i == 0) chk("drop_first_cnt", o_drop_cnt3, 1);
            if (i == 254) chk("drop_cnt_255", o_drop_cnt3, 255);
        end
        i_valid3 = 0;
        tick();
        chk("drop_o_ready_high", bad_ready, 0);
        chk("drop_err_pulses", err_pulses3, 300);
        chk("drop_cnt_saturated", o_drop_cnt3, 255);
        chk("drop_o_valid_low", valid3_seen, 0);
        chk("drop_err_cleared", o_err3, 0);

`ifdef DEMUX_BROADCAST_EN
        // broadcast blocked by stalled ch2
        i_ready = 4'b1011;
        i_valid = 1; i_bcast = 0; i_sltr = 2; i_bus = 16'h2222; exp_q[2].push_back(16'h2222);
        tick();
        i_bcast = 1; i_sltr = 0; i_bus = 16'hBEEF;
        #1 chk("bc_o_ready_low", o_ready, 0);
        tick();
        chk("bc_o_valid_stalled", o_valid, 4'b0100);
        i_ready = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q[k].push_back(16'hBEEF);
        #1 chk("bc_o_ready_release", o_ready, 1);
        tick();
        i_valid = 0; i_bcast = 0;
        chk("bc_o_valid_all", o_valid, 4'b1111);
        chk("bc_o_buses_all", o_buses, {4{16'hBEEF}});
        tick();
`endif

        tick();
        for (int k = 0; k < 4; k++) chk($sformatf("sb_empty_ch%0d", k), exp_q[k].size(), 0);
        chk("full_range_no_err", err_pulses, 0);
        chk("full_range_drop_cnt", o_drop_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
